// File: rtl/ahbl_2m1s_arbiter.sv
// ahbl_2m1s_arbiter
//   Two-master AHB-Lite arbiter/mux driving one master port onto the system bus.
//   M0 is the CPU and M1 is the DMA controller.
//   A master that loses arbitration is stalled through its own HREADY. Its
//   address phase is held in a per-master register and replayed later, so a
//   master that drops HTRANS to IDLE while stalled (the DMAC does) loses nothing.
// Parameters
//   AW, DW    address / data width
//   ARB_MODE  0 = fixed priority (M0 > M1), 1 = round-robin
// Ports
//   HCLK, HRESET                  clock, synchronous active-high reset
//   Mx_HADDR/HTRANS/HSIZE/HWRITE  master address phase (x = 0, 1)
//   Mx_HWDATA                     master write data (data phase)
//   Mx_HREADY/HRDATA/HRESP        master ready, read data, response
//   S_HADDR/HTRANS/HSIZE/HWRITE   granted address phase toward the bus
//   S_HWDATA                      write data of the data-phase owner
//   S_HREADY/HRDATA/HRESP         bus ready, read data, response
module ahbl_2m1s_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic [2:0]    M0_HSIZE,
  input  logic          M0_HWRITE,
  input  logic [DW-1:0] M0_HWDATA,
  output logic          M0_HREADY,
  output logic [DW-1:0] M0_HRDATA,
  output logic          M0_HRESP,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic [2:0]    M1_HSIZE,
  input  logic          M1_HWRITE,
  input  logic [DW-1:0] M1_HWDATA,
  output logic          M1_HREADY,
  output logic [DW-1:0] M1_HRDATA,
  output logic          M1_HRESP,
  output logic [AW-1:0] S_HADDR,
  output logic [1:0]    S_HTRANS,
  output logic [2:0]    S_HSIZE,
  output logic          S_HWRITE,
  output logic [DW-1:0] S_HWDATA,
  input  logic          S_HREADY,
  input  logic [DW-1:0] S_HRDATA,
  input  logic          S_HRESP
);

  logic [1:0]         pend_q, pend_d;
  logic [1:0][AW-1:0] hold_addr_q, hold_addr_d;
  logic [1:0][2:0]    hold_size_q, hold_size_d;
  logic [1:0]         hold_write_q, hold_write_d;
  logic               dp_valid_q, dp_valid_d;
  logic               dp_owner_q, dp_owner_d;
  logic               last_gnt_q, last_gnt_d;

  logic [1:0] hready;
  logic [1:0] live;
  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_sel;

  // Only HTRANS[1] matters: SEQ is forwarded as NONSEQ, bursts are not kept.
  logic unused_htrans;
  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

  always_comb begin
    hready = 2'b11;
    if (!HRESET) begin
      if (pend_q[0])                       hready[0] = 1'b0;
      else if (dp_valid_q && !dp_owner_q)  hready[0] = S_HREADY;
      if (pend_q[1])                       hready[1] = 1'b0;
      else if (dp_valid_q && dp_owner_q)   hready[1] = S_HREADY;
    end

    live[0] = !HRESET && M0_HTRANS[1] && hready[0];
    live[1] = !HRESET && M1_HTRANS[1] && hready[1];
    req     = pend_q | live;

    gnt_valid = !HRESET && S_HREADY && (req != 2'b00);
    if (req == 2'b11) gnt_sel = (ARB_MODE == 0) ? 1'b0 : ~last_gnt_q;
    else              gnt_sel = req[1];

    // Held phase takes precedence: a pending master cannot present a live one.
    if (gnt_sel) begin
      S_HADDR  = pend_q[1] ? hold_addr_q[1]  : M1_HADDR;
      S_HSIZE  = pend_q[1] ? hold_size_q[1]  : M1_HSIZE;
      S_HWRITE = pend_q[1] ? hold_write_q[1] : M1_HWRITE;
    end else begin
      S_HADDR  = pend_q[0] ? hold_addr_q[0]  : M0_HADDR;
      S_HSIZE  = pend_q[0] ? hold_size_q[0]  : M0_HSIZE;
      S_HWRITE = pend_q[0] ? hold_write_q[0] : M0_HWRITE;
    end
    S_HTRANS = gnt_valid ? 2'b10 : 2'b00;
    S_HWDATA = dp_owner_q ? M1_HWDATA : M0_HWDATA;

    M0_HREADY = hready[0];
    M1_HREADY = hready[1];
    M0_HRDATA = S_HRDATA;
    M1_HRDATA = S_HRDATA;
    M0_HRESP  = !HRESET && dp_valid_q && !dp_owner_q && S_HRESP;
    M1_HRESP  = !HRESET && dp_valid_q &&  dp_owner_q && S_HRESP;

    pend_d       = pend_q;
    hold_addr_d  = hold_addr_q;
    hold_size_d  = hold_size_q;
    hold_write_d = hold_write_q;
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    last_gnt_d   = last_gnt_q;

    // Any live phase that is not forwarded this cycle is captured for replay.
    if (live[0] && !(gnt_valid && !gnt_sel)) begin
      pend_d[0]       = 1'b1;
      hold_addr_d[0]  = M0_HADDR;
      hold_size_d[0]  = M0_HSIZE;
      hold_write_d[0] = M0_HWRITE;
    end
    if (live[1] && !(gnt_valid && gnt_sel)) begin
      pend_d[1]       = 1'b1;
      hold_addr_d[1]  = M1_HADDR;
      hold_size_d[1]  = M1_HSIZE;
      hold_write_d[1] = M1_HWRITE;
    end

    if (gnt_valid) begin
      pend_d[gnt_sel] = 1'b0;
      dp_valid_d      = 1'b1;
      dp_owner_d      = gnt_sel;
      last_gnt_d      = gnt_sel;
    end else if (S_HREADY) begin
      dp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q       <= '0;
      hold_addr_q  <= '0;
      hold_size_q  <= '0;
      hold_write_q <= '0;
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= 1'b0;
      last_gnt_q   <= 1'b1;
    end else begin
      pend_q       <= pend_d;
      hold_addr_q  <= hold_addr_d;
      hold_size_q  <= hold_size_d;
      hold_write_q <= hold_write_d;
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

endmodule
